// File: rtl/serial_logic_unit_pkg.sv
// Shared definitions for the serial logic unit: operation encodings and FSM state type.
package serial_logic_unit_pkg;

  localparam logic [1:0] OP_XOR  = 2'b00;
  localparam logic [1:0] OP_AND  = 2'b01;
  localparam logic [1:0] OP_OR   = 2'b10;
  localparam logic [1:0] OP_XNOR = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

endpackage

// File: rtl/chunk_logic.sv
// Combinational bitwise operator applied to one CHUNK-bit slice of the operands.
module chunk_logic
  import serial_logic_unit_pkg::*;
#(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic [1:0]       op,
  output logic [CHUNK-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_XOR:  y = a ^ b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XNOR: y = ~(a ^ b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/serial_logic_unit.sv
// Bit-serial (chunk-serial) bitwise logic unit: one CHUNK slice of the result per BUSY cycle,
// result presented with a valid/ready handshake.
module serial_logic_unit
  import serial_logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero
);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("serial_logic_unit: WIDTH must be a non-zero multiple of CHUNK");
  end

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic [CHUNK-1:0] chunk_y;

  // Single shared slice operator, fed only from the latched operands.
  chunk_logic #(
    .CHUNK(CHUNK)
  ) u_chunk_logic (
    .a (a_q[cnt_q*CHUNK +: CHUNK]),
    .b (b_q[cnt_q*CHUNK +: CHUNK]),
    .op(op_q),
    .y (chunk_y)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    y_d     = y_q;
    zero_d  = zero_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        y_d[cnt_q*CHUNK +: CHUNK] = chunk_y;
        if (cnt_q == LastCnt) begin
          // Flag is taken from the complete result including the slice written now.
          zero_d  = (y_d == '0);
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          zero_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      y_q     <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign y         = y_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_serial_logic_unit.sv
// Self-checking bench: directed and random operations on a 32/4 and an 8/2 instance.
module tb_serial_logic_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] y;
  logic        zero;

  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [1:0]  s_op = 2'b00;
  logic [7:0]  s_a = '0;
  logic [7:0]  s_b = '0;
  logic        s_out_valid;
  logic        s_out_ready = 1'b0;
  logic [7:0]  s_y;
  logic        s_zero;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_logic_unit u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .zero     (zero)
  );

  serial_logic_unit #(
    .WIDTH(8),
    .CHUNK(2)
  ) u_dut_small (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (s_in_valid),
    .in_ready (s_in_ready),
    .op       (s_op),
    .a        (s_a),
    .b        (s_b),
    .out_valid(s_out_valid),
    .out_ready(s_out_ready),
    .y        (s_y),
    .zero     (s_zero)
  );

  // Whole-word reference: the unit must behave as a plain bitwise operator.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] z);
    case (o)
      2'b00:   return x ^ z;
      2'b01:   return x & z;
      2'b10:   return x | z;
      default: return ~(x ^ z);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run32(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb,
                       input int hold);
    logic [31:0] exp_y;
    exp_y = model(o, xa, xb);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; op = o; a = xa; b = xb;
    @(posedge clk); #1;
    // Scramble inputs after acceptance; they must have no effect.
    in_valid = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      if (e < 8) begin
        chk("busy_out_valid", 32'(out_valid), 32'd0);
        chk("busy_zero", 32'(zero), 32'd0);
        chk("busy_in_ready", 32'(in_ready), 32'd0);
      end else begin
        chk("latency_out_valid", 32'(out_valid), 32'd1);
      end
    end
    chk("result_y", y, exp_y);
    chk("result_zero", 32'(zero), 32'(exp_y == 32'd0));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom;
      @(posedge clk); #1;
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_y", y, exp_y);
      chk("hold_zero", 32'(zero), 32'(exp_y == 32'd0));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_y_kept", y, exp_y);
    chk("release_zero", 32'(zero), 32'd0);
  endtask

  task automatic run8(input logic [1:0] o, input logic [7:0] xa, input logic [7:0] xb);
    logic [7:0] exp_y;
    exp_y = 8'(model(o, 32'(xa), 32'(xb)));
    s_in_valid = 1'b1; s_op = o; s_a = xa; s_b = xb;
    @(posedge clk); #1;
    s_in_valid = 1'b0; s_a = 8'($urandom); s_b = 8'($urandom);
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      chk("small_out_valid", 32'(s_out_valid), 32'(e == 4));
    end
    chk("small_y", 32'(s_y), 32'(exp_y));
    chk("small_zero", 32'(s_zero), 32'(exp_y == 8'd0));
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
    chk("small_release", 32'(s_in_ready), 32'd1);
  endtask

  initial begin
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_zero", 32'(zero), 32'd0);
    chk("reset_y", y, 32'd0);
    #12 rst_n = 1'b1;

    run32(2'b00, 32'hFFFF0000, 32'h0F0F0F0F, 0);
    chk("xor_vector_model", model(2'b00, 32'hFFFF0000, 32'h0F0F0F0F), 32'hF0F00F0F);
    run32(2'b01, 32'h12345678, 32'h0000FFFF, 0);
    run32(2'b11, 32'hA5A5A5A5, 32'hA5A5A5A5, 1);
    run32(2'b00, 32'hDEADBEEF, 32'hDEADBEEF, 0);
    run32(2'b10, 32'h00000000, 32'h00000000, 0);
    run32(2'b01, $urandom, $urandom, 5);

    for (int i = 0; i < 12; i++) begin
      run32(2'($urandom), $urandom, $urandom, int'($urandom_range(0, 3)));
    end

    // Reset while chunk 3 is pending.
    in_valid = 1'b1; op = 2'b10; a = 32'hFFFFFFFF; b = 32'h0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_zero", 32'(zero), 32'd0);
    chk("async_rst_y", y, 32'd0);
    chk("async_rst_small_ready", 32'(s_in_ready), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      chk("post_rst_no_valid", 32'(out_valid), 32'd0);
    end

    run8(2'b10, 8'h81, 8'h18);
    chk("small_vector_model", model(2'b10, 32'h81, 32'h18), 32'h99);
    run8(2'b00, 8'h5A, 8'h5A);
    for (int i = 0; i < 6; i++) begin
      run8(2'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_logic_unit.md
SERIAL_LOGIC_UNIT -- requirements
Module: serial_logic_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; must be a multiple of CHUNK.
REQ-002 SHALL have parameter CHUNK, default 4, bits processed per cycle.
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge active.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand/op request valid.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request.
REQ-007 SHALL have port op  input  2  operation: 00 XOR, 01 AND, 10 OR, 11 XNOR.
REQ-008 SHALL have port a  input  WIDTH  operand A.
REQ-009 SHALL have port b  input  WIDTH  operand B.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port y  output  WIDTH  result register.
REQ-013 SHALL have port zero  output  1  high when completed result is all zeros.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE; N = WIDTH/CHUNK.
REQ-015 in_ready SHALL be 1 only in IDLE; in_valid in BUSY/DONE is ignored, not queued.
REQ-016 On in_valid & in_ready at a rising edge: SHALL latch a, b, op; clear chunk counter to 0; enter BUSY.
REQ-017 Each BUSY cycle: SHALL write y[k*CHUNK +: CHUNK] = op(A_k, B_k) for counter k, then increment k.
REQ-018 On the edge writing chunk N-1: SHALL enter DONE, assert out_valid, and register zero from the full result.
REQ-019 Latency: out_valid SHALL rise exactly N clock edges after the accepting edge (8 for defaults).
REQ-020 In DONE: y, zero, out_valid SHALL hold stable while out_ready = 0.
REQ-021 On out_valid & out_ready at an edge: SHALL return to IDLE and deassert out_valid; in_ready rises the same edge; y keeps its value.
REQ-022 Counter SHALL be $clog2(N) bits (min 1) and never exceed N-1.
REQ-023 Operands and op SHALL be taken only from latched copies during BUSY; input changes after acceptance have no effect.
REQ-024 y is meaningful only while out_valid = 1; zero SHALL be 0 except in DONE.

Reset
REQ-025 rst_n low SHALL immediately force IDLE: in_ready = 1, out_valid = 0, zero = 0, y = 0, counter = 0, latched operands = 0.
REQ-026 Reset mid-BUSY or mid-DONE SHALL discard the operation; no out_valid after release.
REQ-027 First request SHALL be accepted on the first rising edge with rst_n high and in_valid high.

Structure
REQ-028 Shared package SHALL hold op encodings (OP_XOR, OP_AND, OP_OR, OP_XNOR) and the state typedef.
REQ-029 SHALL instantiate one combinational sub-module chunk_logic (CHUNK-bit a, b, op -> CHUNK-bit result), one instance reused per cycle.
REQ-030 Elaboration SHALL fail if WIDTH % CHUNK != 0 or CHUNK < 1.

Verification
REQ-031 XOR: a = 0xFFFF0000, b = 0x0F0F0F0F, op = 00 -> out_valid 8 edges later, y = 0xF0F00F0F, zero = 0.
REQ-032 AND / XNOR: a = 0x12345678, b = 0x0000FFFF, op = 01 -> y = 0x00005678; op = 11, a = b = 0xA5A5A5A5 -> y = 0xFFFFFFFF.
REQ-033 Zero flag: op = 00, a = b = 0xDEADBEEF -> y = 0x00000000, zero = 1.
REQ-034 Backpressure: out_ready held 0 for 5 cycles after out_valid -> y and zero stable, in_ready = 0, new in_valid ignored; out_ready = 1 -> IDLE next edge.
REQ-035 Reset: rst_n pulsed low at chunk 3 of BUSY -> outputs at reset values asynchronously; no out_valid follows.
REQ-036 Parameter: WIDTH = 8, CHUNK = 2, op = 10, a = 0x81, b = 0x18 -> y = 0x99 after 4 edges.
